// File: rtl/uvme_cvmcu_chip_strap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvme_cvmcu_chip_strap_pkg : shared types for the chip strap control |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uvme_cvmcu_chip_strap_pkg;

  typedef enum logic [1:0] {
    STRAP_IDLE    = 2'd0,
    STRAP_DELAY   = 2'd1,
    STRAP_HOLD    = 2'd2,
    STRAP_RESTORE = 2'd3
  } strap_state_e;

  typedef enum int {
    EDGE_BOTH = 0,
    EDGE_RISE = 1,
    EDGE_FALL = 2
  } edge_mode_e;

  function automatic int ch_idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uvme_cvmcu_chip_edge_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvme_cvmcu_chip_edge_counter : probe sync, edge detect, sat counter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uvme_cvmcu_chip_edge_counter
  import uvme_cvmcu_chip_strap_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             probe_i,
  output logic             sync_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic             meta_q, sync_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             edge_hit;

  always_comb begin
    if (EDGE_MODE == EDGE_RISE)      edge_hit = sync_q & ~prev_q;
    else if (EDGE_MODE == EDGE_FALL) edge_hit = ~sync_q & prev_q;
    else                             edge_hit = sync_q ^ prev_q;
  end

  // A clear wins over a coincident edge; an edge at full scale only flags overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (edge_hit) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      meta_q <= probe_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sync_o = sync_q;
  assign cnt_o  = cnt_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/uvme_cvmcu_chip_strap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uvme_cvmcu_chip_strap_ctrl : timed strap channels + probe counters  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uvme_cvmcu_chip_strap_ctrl
  import uvme_cvmcu_chip_strap_pkg::*;
#(
  parameter int                         NUM_CH      = 2,
  parameter int                         CH_WIDTH    = 1,
  parameter logic [NUM_CH*CH_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                         DLY_W       = 16,
  parameter int                         NUM_PROBES  = 4,
  parameter int                         CNT_W       = 8,
  parameter int                         EDGE_MODE   = 0,
  localparam int                        CH_IDX_W    = ch_idx_width(NUM_CH)
) (
  input  logic                        ref_clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [CH_IDX_W-1:0]         req_ch_i,
  input  logic [CH_WIDTH-1:0]         req_value_i,
  input  logic [DLY_W-1:0]            req_delay_i,
  input  logic [DLY_W-1:0]            req_hold_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [NUM_CH*CH_WIDTH-1:0]  strap_o,
  input  logic [NUM_PROBES-1:0]       probe_i,
  output logic [NUM_PROBES-1:0]       probe_sync_o,
  input  logic                        cnt_clr_i,
  output logic [NUM_PROBES*CNT_W-1:0] edge_cnt_o,
  output logic [NUM_PROBES-1:0]       ovf_o
);

  localparam logic [1:0] S_IDLE    = STRAP_IDLE;
  localparam logic [1:0] S_DELAY   = STRAP_DELAY;
  localparam logic [1:0] S_HOLD    = STRAP_HOLD;
  localparam logic [1:0] S_RESTORE = STRAP_RESTORE;

  logic [1:0]                state_q, state_d;
  logic [CH_IDX_W-1:0]       ch_q, ch_d;
  logic [CH_WIDTH-1:0]       val_q, val_d, saved_q, saved_d;
  logic [DLY_W-1:0]          hold_q, hold_d, cnt_q, cnt_d;
  logic [NUM_CH*CH_WIDTH-1:0] strap_q, strap_d;
  logic                      done_q, done_d, err_q, err_d, inv_q, inv_d;
  logic                      rdy_en_q;
  logic                      accept, ch_bad, wr_en;
  logic [CH_WIDTH-1:0]       wr_val, cur_field;

  assign req_ready_o = rdy_en_q & (state_q == S_IDLE) & ~inv_q & ~done_q;
  assign accept      = req_valid_i & req_ready_o;
  assign ch_bad      = int'(req_ch_i) >= NUM_CH;

  always_comb begin
    cur_field = '0;
    strap_d   = strap_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_IDX_W'(c)) begin
        cur_field = strap_q[c*CH_WIDTH +: CH_WIDTH];
        if (wr_en) strap_d[c*CH_WIDTH +: CH_WIDTH] = wr_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    val_d   = val_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    saved_d = saved_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    inv_d   = 1'b0;
    wr_en   = 1'b0;
    wr_val  = val_q;
    case (state_q)
      S_IDLE: begin
        if (inv_q) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (accept) begin
          if (ch_bad) begin
            inv_d = 1'b1;
          end else begin
            ch_d    = req_ch_i;
            val_d   = req_value_i;
            hold_d  = req_hold_i;
            cnt_d   = req_delay_i;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (abort_i) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          wr_en   = 1'b1;
          saved_d = cur_field;
          // RESTORE writes one edge after it is entered, so HOLD counts hold-1.
          if (hold_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (hold_q == DLY_W'(1)) begin
            state_d = S_RESTORE;
          end else begin
            cnt_d   = hold_q - 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          wr_en   = 1'b1;
          wr_val  = saved_q;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == DLY_W'(1)) begin
          state_d = S_RESTORE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESTORE: begin
        wr_en   = 1'b1;
        wr_val  = saved_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      val_q    <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      saved_q  <= '0;
      strap_q  <= RESET_VALUE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      inv_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      val_q    <= val_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      saved_q  <= saved_d;
      strap_q  <= strap_d;
      done_q   <= done_d;
      err_q    <= err_d;
      inv_q    <= inv_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign strap_o = strap_q;

  for (genvar p = 0; p < NUM_PROBES; p++) begin : g_probe
    uvme_cvmcu_chip_edge_counter #(
      .CNT_W     (CNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_edge_counter (
      .clk_i   (ref_clk_i),
      .rst_i   (rst_i),
      .clr_i   (cnt_clr_i),
      .probe_i (probe_i[p]),
      .sync_o  (probe_sync_o[p]),
      .cnt_o   (edge_cnt_o[p*CNT_W +: CNT_W]),
      .ovf_o   (ovf_o[p])
    );
  end

endmodule
`default_nettype wire
